// File: rtl/vx_csr_access_sched_if.sv
// Requester-side handshake bundle for vx_csr_access_sched: per-requester request lanes plus
// the shared response channel. master = requesters, slave = scheduler.
interface vx_csr_access_sched_if #(
    parameter int unsigned NUM_REQS  = 2,
    parameter int unsigned NW_BITS   = 2,
    parameter int unsigned ADDR_BITS = 12,
    parameter int unsigned UUID_BITS = 44,
    parameter int unsigned IDX_BITS  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
);
    logic [NUM_REQS-1:0]           req_valid;
    logic [NUM_REQS-1:0]           req_ready;
    logic [2*NUM_REQS-1:0]         req_op;
    logic [ADDR_BITS*NUM_REQS-1:0] req_addr;
    logic [NW_BITS*NUM_REQS-1:0]   req_wid;
    logic [32*NUM_REQS-1:0]        req_data;
    logic [UUID_BITS*NUM_REQS-1:0] req_uuid;
    logic                          rsp_valid;
    logic [IDX_BITS-1:0]           rsp_idx;
    logic [31:0]                   rsp_data;
    logic                          rsp_ready;

    modport master (
        output req_valid, req_op, req_addr, req_wid, req_data, req_uuid, rsp_ready,
        input  req_ready, rsp_valid, rsp_idx, rsp_data
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wid, req_data, req_uuid, rsp_ready,
        output req_ready, rsp_valid, rsp_idx, rsp_data
    );
endinterface

// File: rtl/vx_csr_access_sched.sv
// Round-robin scheduler performing atomic read-then-optional-write CSR accesses for NUM_REQS
// requesters. Define CSR_SCHED_PERF_EN to add perf_grants/perf_stalls counters.
module vx_csr_access_sched #(
    parameter int unsigned NUM_REQS  = 2,
    parameter int unsigned NW_BITS   = 2,
    parameter int unsigned ADDR_BITS = 12,
    parameter int unsigned UUID_BITS = 44
) (
    input  logic                 clk,
    input  logic                 reset,
    vx_csr_access_sched_if.slave bus,
    output logic                 csr_read_enable,
    output logic [ADDR_BITS-1:0] csr_read_addr,
    output logic [NW_BITS-1:0]   csr_read_wid,
    output logic [UUID_BITS-1:0] csr_read_uuid,
    input  logic [31:0]          csr_read_data,
    output logic                 csr_write_enable,
    output logic [ADDR_BITS-1:0] csr_write_addr,
    output logic [NW_BITS-1:0]   csr_write_wid,
    output logic [UUID_BITS-1:0] csr_write_uuid,
    output logic [31:0]          csr_write_data,
    output logic                 busy
`ifdef CSR_SCHED_PERF_EN
    ,
    output logic [31:0]          perf_grants,
    output logic [31:0]          perf_stalls
`endif
);
    localparam int unsigned IDX_BITS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    localparam logic [1:0] OpRead  = 2'd0;
    localparam logic [1:0] OpWrite = 2'd1;
    localparam logic [1:0] OpSet   = 2'd2;

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StRsp} state_e;

    state_e               state_q;
    logic [IDX_BITS-1:0]  rr_ptr_q;
    logic [IDX_BITS-1:0]  idx_q;
    logic [1:0]           op_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [NW_BITS-1:0]   wid_q;
    logic [31:0]          data_q;
    logic [UUID_BITS-1:0] uuid_q;
    logic [31:0]          old_q;
    logic [31:0]          wdata_q;
    logic                 rd_en_q;
    logic                 wr_en_q;
    logic                 rsp_valid_q;

    logic                 grant_valid;
    logic [IDX_BITS-1:0]  grant_idx;
    logic [IDX_BITS:0]    cand_w;
    logic [NUM_REQS-1:0]  req_ready_w;

    // Scan requesters starting at rr_ptr, wrapping at NUM_REQS (need not be a power of two).
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand_w      = '0;
        for (int k = 0; k < int'(NUM_REQS); k++) begin
            cand_w = {1'b0, rr_ptr_q} + (IDX_BITS+1)'(k);
            if (cand_w >= (IDX_BITS+1)'(NUM_REQS)) begin
                cand_w = cand_w - (IDX_BITS+1)'(NUM_REQS);
            end
            if (!grant_valid && bus.req_valid[cand_w[IDX_BITS-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_w[IDX_BITS-1:0];
            end
        end
    end

    always_comb begin
        req_ready_w = '0;
        if (reset && state_q == StIdle && grant_valid) begin
            req_ready_w = NUM_REQS'(1) << grant_idx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            idx_q       <= '0;
            op_q        <= '0;
            addr_q      <= '0;
            wid_q       <= '0;
            data_q      <= '0;
            uuid_q      <= '0;
            old_q       <= '0;
            wdata_q     <= '0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant_valid) begin
                        idx_q    <= grant_idx;
                        op_q     <= bus.req_op[2*int'(grant_idx) +: 2];
                        addr_q   <= bus.req_addr[ADDR_BITS*int'(grant_idx) +: ADDR_BITS];
                        wid_q    <= bus.req_wid[NW_BITS*int'(grant_idx) +: NW_BITS];
                        data_q   <= bus.req_data[32*int'(grant_idx) +: 32];
                        uuid_q   <= bus.req_uuid[UUID_BITS*int'(grant_idx) +: UUID_BITS];
                        rr_ptr_q <= (grant_idx == IDX_BITS'(NUM_REQS - 1)) ? '0
                                                                          : grant_idx + 1'b1;
                        rd_en_q  <= 1'b1;
                        state_q  <= StRead;
                    end
                end
                StRead: begin
                    old_q   <= csr_read_data;
                    rd_en_q <= 1'b0;
                    // Set/clear with a zero operand must not touch the CSR.
                    if (op_q == OpRead || (op_q != OpWrite && data_q == '0)) begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= StRsp;
                    end else begin
                        if (op_q == OpWrite) begin
                            wdata_q <= data_q;
                        end else if (op_q == OpSet) begin
                            wdata_q <= csr_read_data | data_q;
                        end else begin
                            wdata_q <= csr_read_data & ~data_q;
                        end
                        wr_en_q <= 1'b1;
                        state_q <= StWrite;
                    end
                end
                StWrite: begin
                    wr_en_q     <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= StRsp;
                end
                StRsp: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.req_ready     = req_ready_w;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_idx       = idx_q;
    assign bus.rsp_data      = old_q;
    assign csr_read_enable   = rd_en_q;
    assign csr_read_addr     = addr_q;
    assign csr_read_wid      = wid_q;
    assign csr_read_uuid     = uuid_q;
    assign csr_write_enable  = wr_en_q;
    assign csr_write_addr    = addr_q;
    assign csr_write_wid     = wid_q;
    assign csr_write_uuid    = uuid_q;
    assign csr_write_data    = wdata_q;
    assign busy              = (state_q != StIdle);

`ifdef CSR_SCHED_PERF_EN
    logic [31:0] perf_grants_q;
    logic [31:0] perf_stalls_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_grants_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            if (|req_ready_w) begin
                perf_grants_q <= perf_grants_q + 32'd1;
            end
            if (|bus.req_valid && !(|req_ready_w)) begin
                perf_stalls_q <= perf_stalls_q + 32'd1;
            end
        end
    end

    assign perf_grants = perf_grants_q;
    assign perf_stalls = perf_stalls_q;
`endif
endmodule

// File: tb/tb_vx_csr_access_sched.sv
// Randomized bench for vx_csr_access_sched against a transaction-level timing model with a
// shadow CSR array; directed cases cover read/set/clear, zero-operand, backpressure and reset.
module tb_vx_csr_access_sched;
    localparam int unsigned NUM_REQS  = 2;
    localparam int unsigned NW_BITS   = 2;
    localparam int unsigned ADDR_BITS = 12;
    localparam int unsigned UUID_BITS = 44;
    localparam int unsigned IDX_BITS  = 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    vx_csr_access_sched_if #(
        .NUM_REQS(NUM_REQS), .NW_BITS(NW_BITS), .ADDR_BITS(ADDR_BITS), .UUID_BITS(UUID_BITS),
        .IDX_BITS(IDX_BITS)
    ) bus ();

    logic                 csr_read_enable;
    logic [ADDR_BITS-1:0] csr_read_addr;
    logic [NW_BITS-1:0]   csr_read_wid;
    logic [UUID_BITS-1:0] csr_read_uuid;
    logic [31:0]          csr_read_data;
    logic                 csr_write_enable;
    logic [ADDR_BITS-1:0] csr_write_addr;
    logic [NW_BITS-1:0]   csr_write_wid;
    logic [UUID_BITS-1:0] csr_write_uuid;
    logic [31:0]          csr_write_data;
    logic                 busy;
`ifdef CSR_SCHED_PERF_EN
    logic [31:0]          perf_grants;
    logic [31:0]          perf_stalls;
`endif

    vx_csr_access_sched #(
        .NUM_REQS(NUM_REQS), .NW_BITS(NW_BITS), .ADDR_BITS(ADDR_BITS), .UUID_BITS(UUID_BITS)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus),
        .csr_read_enable  (csr_read_enable),
        .csr_read_addr    (csr_read_addr),
        .csr_read_wid     (csr_read_wid),
        .csr_read_uuid    (csr_read_uuid),
        .csr_read_data    (csr_read_data),
        .csr_write_enable (csr_write_enable),
        .csr_write_addr   (csr_write_addr),
        .csr_write_wid    (csr_write_wid),
        .csr_write_uuid   (csr_write_uuid),
        .csr_write_data   (csr_write_data),
        .busy             (busy)
`ifdef CSR_SCHED_PERF_EN
        ,
        .perf_grants      (perf_grants),
        .perf_stalls      (perf_stalls)
`endif
    );

    // CSR block stand-in (addresses 0x300..0x30F) and the model's own copy of it.
    logic [31:0] csr_mem [16];
    logic [31:0] ref_mem [16];
    assign csr_read_data = csr_mem[csr_read_addr[3:0]];
    always @(posedge clk) begin
        if (csr_write_enable) csr_mem[csr_write_addr[3:0]] <= csr_write_data;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction model: a grant at offset 0 implies read at +1, write at +2 when the op
    // modifies the CSR, and a response from +2 (no write) or +3 (write) until rsp_ready.
    bit          m_busy = 0;
    int          m_t, m_idx, m_rsp_t;
    int          m_ptr = 0;
    logic [1:0]  m_op;
    logic [11:0] m_addr;
    logic [1:0]  m_wid;
    logic [43:0] m_uuid;
    logic [31:0] m_d, m_old, m_new;
    bit          m_wr;
    logic [31:0] m_grants = 0;
    logic [31:0] m_stalls = 0;

    task automatic model_step();
        int w;
        logic [NUM_REQS-1:0] exp_ready;
        exp_ready = '0;
        w = -1;
`ifdef CSR_SCHED_PERF_EN
        check("perf_grants", perf_grants, m_grants);
        check("perf_stalls", perf_stalls, m_stalls);
`endif
        if (m_busy) begin
            m_t++;
            check("busy", busy, 1);
            check("ready_busy", bus.req_ready, 0);
            check("rd_en", csr_read_enable, m_t == 1);
            check("wr_en", csr_write_enable, m_wr && m_t == 2);
            check("rsp_valid", bus.rsp_valid, m_t >= m_rsp_t);
            if (m_t == 1) begin
                check("rd_addr", csr_read_addr, m_addr);
                check("rd_wid", csr_read_wid, m_wid);
                check("rd_uuid", csr_read_uuid, m_uuid);
            end
            if (m_wr && m_t == 2) begin
                check("wr_addr", csr_write_addr, m_addr);
                check("wr_wid", csr_write_wid, m_wid);
                check("wr_uuid", csr_write_uuid, m_uuid);
                check("wr_data", csr_write_data, m_new);
                ref_mem[m_addr[3:0]] = m_new;
            end
            if (m_t >= m_rsp_t) begin
                check("rsp_data", bus.rsp_data, m_old);
                check("rsp_idx", bus.rsp_idx, m_idx);
                if (bus.rsp_ready) m_busy = 0;
            end
        end else begin
            for (int k = 0; k < int'(NUM_REQS); k++) begin
                int c;
                c = (m_ptr + k) % int'(NUM_REQS);
                if (w < 0 && bus.req_valid[c]) w = c;
            end
            if (w >= 0) exp_ready[w] = 1'b1;
            check("busy_idle", busy, 0);
            check("ready", bus.req_ready, exp_ready);
            check("idle_quiet", {csr_read_enable, csr_write_enable, bus.rsp_valid}, 0);
            if (w >= 0) begin
                m_busy  = 1;
                m_t     = 0;
                m_idx   = w;
                m_op    = bus.req_op[2*w +: 2];
                m_addr  = bus.req_addr[12*w +: 12];
                m_wid   = bus.req_wid[2*w +: 2];
                m_d     = bus.req_data[32*w +: 32];
                m_uuid  = bus.req_uuid[44*w +: 44];
                m_old   = ref_mem[m_addr[3:0]];
                m_wr    = (m_op == 2'd1) || (m_op != 2'd0 && m_d != 0);
                m_new   = (m_op == 2'd1) ? m_d : (m_op == 2'd2) ? (m_old | m_d) : (m_old & ~m_d);
                m_rsp_t = m_wr ? 3 : 2;
                m_ptr   = (w + 1) % int'(NUM_REQS);
                m_grants++;
            end
        end
        if (|bus.req_valid && exp_ready == 0) m_stalls++;
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_req_rsp"}, {bus.req_ready, bus.rsp_valid, bus.rsp_idx, bus.rsp_data}, 0);
        check({tag, "_rd"}, {csr_read_enable, csr_read_addr, csr_read_wid}, 0);
        check({tag, "_rd_uuid"}, csr_read_uuid, 0);
        check({tag, "_wr"}, {csr_write_enable, csr_write_addr, csr_write_wid, csr_write_data}, 0);
        check({tag, "_wr_uuid"}, csr_write_uuid, 0);
        check({tag, "_busy"}, busy, 0);
`ifdef CSR_SCHED_PERF_EN
        check({tag, "_perf"}, {perf_grants, perf_stalls}, 0);
`endif
    endtask

    task automatic preload(input logic [11:0] addr, input logic [31:0] val);
        csr_mem[addr[3:0]] = val;
        ref_mem[addr[3:0]] = val;
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [11:0] addr,
                           input logic [31:0] d);
        logic [63:0] u;
        u = {$urandom, $urandom};
        bus.req_valid[i]           = 1'b1;
        bus.req_op[2*i +: 2]       = op;
        bus.req_addr[12*i +: 12]   = addr;
        bus.req_wid[2*i +: 2]      = 2'($urandom);
        bus.req_data[32*i +: 32]   = d;
        bus.req_uuid[44*i +: 44]   = u[43:0];
    endtask

    task automatic rand_req(input int i);
        logic [31:0] d;
        d = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
        set_req(i, 2'($urandom), 12'h300 + 12'($urandom_range(0, 7)), d);
        bus.req_valid[i] = ($urandom_range(0, 9) < 7);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (m_busy && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_drained"}, m_busy, 0);
    endtask

    task automatic run_txn(input string tag, input int i, input logic [1:0] op,
                           input logic [11:0] addr, input logic [31:0] d);
        bus.req_valid = '0;
        set_req(i, op, addr, d);
        tick();
        bus.req_valid = '0;
        drain(tag);
    endtask

    initial begin
        for (int a = 0; a < 16; a++) preload(12'h300 + 12'(a), $urandom);
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_addr  = '0;
        bus.req_wid   = '0;
        bus.req_data  = '0;
        bus.req_uuid  = '0;
        bus.rsp_ready = 1'b1;
        #1;
        check_zero("por");
        @(posedge clk);
        #1;
        reset = 1'b1;

        preload(12'h300, 32'h1800);
        run_txn("read", 0, 2'd0, 12'h300, 32'h0);
        preload(12'h305, 32'hF0);
        run_txn("set", 1, 2'd2, 12'h305, 32'h0F);
        check("set_mem", csr_mem[5], 32'hFF);
        run_txn("clear", 0, 2'd3, 12'h305, 32'h30);
        check("clear_mem", csr_mem[5], 32'hCF);
        run_txn("set_zero", 1, 2'd2, 12'h305, 32'h0);
        check("set_zero_mem", csr_mem[5], 32'hCF);
        run_txn("write", 0, 2'd1, 12'h306, 32'hDEAD_BEEF);

        // Both requesters continuously valid: grants alternate.
        for (int c = 0; c < 16; c++) begin
            rand_req(0);
            rand_req(1);
            bus.req_valid = 2'b11;
            tick();
        end
        // Response backpressure with requests pending.
        bus.rsp_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            bus.req_valid = 2'b11;
            tick();
        end
        bus.rsp_ready = 1'b1;
        bus.req_valid = '0;
        drain("bp");

        // Reset during the READ cycle of a write.
        preload(12'h302, 32'h0F0F);
        bus.req_valid = '0;
        set_req(1, 2'd1, 12'h302, 32'h1234);
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        model_step();
        reset = 1'b0;
        #1;
        check_zero("rst");
        m_busy = 0;
        m_ptr = 0;
        m_grants = 0;
        m_stalls = 0;
        @(negedge clk);
        check_zero("rst_hold");
        @(posedge clk);
        #1;
        check("rst_nowrite_mem", csr_mem[2], 32'h0F0F);
        set_req(1, 2'd0, 12'h302, 32'h0);
        reset = 1'b1;
        tick();
        check("post_rst_grant", m_idx, 1);
        bus.req_valid = '0;
        drain("post_rst");

        for (int c = 0; c < 500; c++) begin
            rand_req(0);
            rand_req(1);
            bus.rsp_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        drain("final");
        for (int a = 0; a < 16; a++) check("mem_final", csr_mem[a], ref_mem[a]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
